// File: rtl/video_bus_pkg.sv
// Shared types for the video fetch bus: arbiter FSM states, fetch-channel index
// and the default burst length.
package video_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_TURN = 2'd3
  } bus_state_t;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } fetch_ch_t;

  localparam int BURST_LEN_DEFAULT = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way request arbiter: round-robin on the last served channel, or fixed
// priority to ch0 when FIXED_PRIO is set.
module rr_arbiter2
  import video_bus_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_valid,
  output fetch_ch_t  o_grant
);

  fetch_ch_t r_last;
  fetch_ch_t w_grant;

  // Tie-break goes to the channel that was not served last.
  always_comb begin
    w_grant = CH0;
    if (i_req == 2'b11) begin
      if (FIXED_PRIO) begin
        w_grant = CH0;
      end else begin
        w_grant = (r_last == CH0) ? CH1 : CH0;
      end
    end else if (i_req[1]) begin
      w_grant = CH1;
    end else begin
      w_grant = CH0;
    end
  end

  // Last-served pointer; reset value makes ch0 the first preferred channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= CH1;
    end else if (i_take && o_valid) begin
      r_last <= w_grant;
    end
  end

  assign o_valid = |i_req;
  assign o_grant = w_grant;

endmodule

// File: rtl/ica_burst_arbiter.sv
// Arbitrates the two ICA/DCA fetch channels onto one linear-burst memory port
// and streams each burst back to the granted channel, closing with bus_ack.
module ica_burst_arbiter
  import video_bus_pkg::*;
#(
  parameter int BURST_LEN  = BURST_LEN_DEFAULT,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ch0_as,
  input  logic [21:0] ch0_address,
  output logic        ch0_burstdata_valid,
  output logic        ch0_bus_ack,
  output logic [15:0] ch0_din,
  input  logic        ch1_as,
  input  logic [21:0] ch1_address,
  output logic        ch1_burstdata_valid,
  output logic        ch1_bus_ack,
  output logic [15:0] ch1_din,
  output logic        mem_req,
  output logic [20:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int            CW       = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

  bus_state_t    r_state;
  bus_state_t    w_state_nxt;
  fetch_ch_t     r_grant;
  fetch_ch_t     w_arb_grant;
  logic          w_arb_valid;
  logic          w_take;
  logic          w_last;
  logic [CW-1:0] r_cnt;
  logic          r_mem_req;
  logic [20:0]   r_mem_addr;
  logic [20:0]   w_sel_addr;
  logic [15:0]   r_ch0_din;
  logic [15:0]   r_ch1_din;
  logic          r_ch0_valid;
  logic          r_ch0_ack;
  logic          r_ch1_valid;
  logic          r_ch1_ack;
  logic          w_unused_addr_lsb;

  rr_arbiter2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .i_req  ({ch1_as, ch0_as}),
    .i_take (w_take),
    .o_valid(w_arb_valid),
    .o_grant(w_arb_grant)
  );

  assign w_last            = (r_cnt == LAST_IDX);
  assign w_sel_addr        = (w_arb_grant == CH1) ? ch1_address[21:1] : ch0_address[21:1];
  assign w_unused_addr_lsb = ch0_address[0] ^ ch1_address[0];

  // Next-state logic; TURN gives requesters one cycle to update as/address.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_state_nxt = ST_REQ;
          w_take      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_DATA: begin
        if (mem_rvalid && w_last) begin
          w_state_nxt = ST_TURN;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_TURN: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request, counter and per-channel return path; valid/ack are single pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant     <= CH0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 21'd0;
      r_ch0_din   <= 16'd0;
      r_ch1_din   <= 16'd0;
      r_ch0_valid <= 1'b0;
      r_ch0_ack   <= 1'b0;
      r_ch1_valid <= 1'b0;
      r_ch1_ack   <= 1'b0;
    end else begin
      r_ch0_valid <= 1'b0;
      r_ch0_ack   <= 1'b0;
      r_ch1_valid <= 1'b0;
      r_ch1_ack   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_grant    <= w_arb_grant;
            r_mem_addr <= w_sel_addr;
            r_mem_req  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
          end
        end
        ST_DATA: begin
          if (mem_rvalid) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_grant == CH1) begin
              r_ch1_din   <= mem_rdata;
              r_ch1_valid <= 1'b1;
              r_ch1_ack   <= w_last;
            end else begin
              r_ch0_din   <= mem_rdata;
              r_ch0_valid <= 1'b1;
              r_ch0_ack   <= w_last;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_req             = r_mem_req;
  assign mem_addr            = r_mem_addr;
  assign ch0_din             = r_ch0_din;
  assign ch0_burstdata_valid = r_ch0_valid;
  assign ch0_bus_ack         = r_ch0_ack;
  assign ch1_din             = r_ch1_din;
  assign ch1_burstdata_valid = r_ch1_valid;
  assign ch1_bus_ack         = r_ch1_ack;

endmodule

// File: tb/tb_ica_burst_arbiter.sv
// Bench for ica_burst_arbiter: a round-robin instance (A) and a fixed-priority
// instance (B) share stimulus; expected words and addresses are queued up front.
module tb_ica_burst_arbiter;

  typedef struct {
    logic        ch;
    logic [15:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ch0_as, ch1_as;
  logic [21:0] ch0_address, ch1_address;
  logic mem_ack, mem_rvalid;
  logic [15:0] mem_rdata;

  logic a_v0, a_k0, a_v1, a_k1, a_req;
  logic [15:0] a_d0, a_d1;
  logic [20:0] a_addr;
  logic b_v0, b_k0, b_v1, b_k1, b_req;
  logic [15:0] b_d0, b_d1;
  logic [20:0] b_addr;

  exp_t qa[$];
  exp_t qb[$];
  logic [20:0] qaa[$];
  logic [20:0] qba[$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc_cnt = 0;
  int t_req   = 0;
  logic pa, pb;

  ica_burst_arbiter #(.BURST_LEN(4), .FIXED_PRIO(1'b0)) dut_a (
    .clk(clk), .reset(reset),
    .ch0_as(ch0_as), .ch0_address(ch0_address), .ch0_burstdata_valid(a_v0),
    .ch0_bus_ack(a_k0), .ch0_din(a_d0),
    .ch1_as(ch1_as), .ch1_address(ch1_address), .ch1_burstdata_valid(a_v1),
    .ch1_bus_ack(a_k1), .ch1_din(a_d1),
    .mem_req(a_req), .mem_addr(a_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  ica_burst_arbiter #(.BURST_LEN(4), .FIXED_PRIO(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .ch0_as(ch0_as), .ch0_address(ch0_address), .ch0_burstdata_valid(b_v0),
    .ch0_bus_ack(b_k0), .ch0_din(b_d0),
    .ch1_as(ch1_as), .ch1_address(ch1_address), .ch1_burstdata_valid(b_v1),
    .ch1_bus_ack(b_k1), .ch1_din(b_d1),
    .mem_req(b_req), .mem_addr(b_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_data(input logic w, input logic v0, input logic k0, input logic v1,
                          input logic k1, input logic [15:0] d0, input logic [15:0] d1);
    exp_t  e;
    string p;
    p = w ? "B." : "A.";
    if (v0 || v1 || k0 || k1) begin
      if ((w ? qb.size() : qa.size()) == 0) begin
        chk({p, "unexpected_output"}, 32'd1, 32'd0);
      end else begin
        if (w) e = qb.pop_front();
        else   e = qa.pop_front();
        chk({p, "valid_route"}, {30'd0, v1, v0}, e.ch ? 32'd2 : 32'd1);
        chk({p, "din"}, e.ch ? d1 : d0, e.data);
        chk({p, "bus_ack"}, {30'd0, k1, k0}, e.last ? (e.ch ? 32'd2 : 32'd1) : 32'd0);
        chk({p, "latency"}, cyc_cnt, e.cyc);
      end
    end
  endtask

  // Output monitor: pops the scoreboard on every data/ack pulse and mem_req rise.
  always @(negedge clk) begin
    if (reset) begin
      pa <= 1'b0;
      pb <= 1'b0;
    end else begin
      mon_data(1'b0, a_v0, a_k0, a_v1, a_k1, a_d0, a_d1);
      mon_data(1'b1, b_v0, b_k0, b_v1, b_k1, b_d0, b_d1);
      if (a_req && !pa) begin
        if (qaa.size() == 0) chk("A.unexpected_req", 32'd1, 32'd0);
        else                 chk("A.mem_addr", a_addr, qaa.pop_front());
      end
      if (b_req && !pb) begin
        if (qba.size() == 0) chk("B.unexpected_req", 32'd1, 32'd0);
        else                 chk("B.mem_addr", b_addr, qba.pop_front());
      end
      pa <= a_req;
      pb <= b_req;
    end
  end

  task automatic chk_zero(input string p);
    chk({p, ".A.mem_req"}, a_req, 32'd0);
    chk({p, ".A.mem_addr"}, a_addr, 32'd0);
    chk({p, ".A.outs"}, {a_v0, a_k0, a_v1, a_k1}, 32'd0);
    chk({p, ".A.ch0_din"}, a_d0, 32'd0);
    chk({p, ".A.ch1_din"}, a_d1, 32'd0);
    chk({p, ".B.mem_req"}, b_req, 32'd0);
    chk({p, ".B.mem_addr"}, b_addr, 32'd0);
    chk({p, ".B.outs"}, {b_v0, b_k0, b_v1, b_k1}, 32'd0);
    chk({p, ".B.ch0_din"}, b_d0, 32'd0);
    chk({p, ".B.ch1_din"}, b_d1, 32'd0);
  endtask

  task automatic wait_req();
    int guard;
    guard = 0;
    while (!a_req && guard < 40) begin
      cyc();
      guard++;
    end
    chk("mem_req_timeout", a_req, 32'd1);
    t_req = cyc_cnt;
  endtask

  // Memory responder: ack after ack_dly cycles, then rvalid per pattern (LSB first).
  task automatic serve(input int ack_dly, input logic [15:0] pat, input int plen,
                       input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                       input logic [15:0] d3, input logic cha, input logic chb);
    logic [15:0] dw [4];
    exp_t e;
    int k;
    dw[0] = d0; dw[1] = d1; dw[2] = d2; dw[3] = d3;
    wait_req();
    repeat (ack_dly) cyc();
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    k = 0;
    for (int i = 0; i < plen; i++) begin
      mem_rvalid = pat[i];
      mem_rdata  = 16'hDEAD;
      if (pat[i]) begin
        mem_rdata = dw[k];
        e.data = dw[k];
        e.last = (k == 3);
        e.cyc  = cyc_cnt + 1;
        e.ch   = cha; qa.push_back(e);
        e.ch   = chb; qb.push_back(e);
        k++;
      end
      cyc();
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_first;
    exp_t e;
    reset = 1'b1; ch0_as = 1'b0; ch1_as = 1'b0;
    ch0_address = 22'd0; ch1_address = 22'd0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'd0;
    repeat (3) cyc();
    chk_zero("reset");
    reset = 1'b0;
    cyc();

    // Single ch0 burst, ack two cycles after the request.
    ch0_address = 22'h000400; ch0_as = 1'b1;
    qaa.push_back(21'h000200); qba.push_back(21'h000200);
    serve(2, 16'h000F, 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 1'b0);
    ch0_as = 1'b0;
    cyc(); cyc();
    chk("t1.A.ch1_din", a_d1, 32'd0);
    chk("t1.B.ch1_din", b_d1, 32'd0);
    chk("t1.drain", qa.size() + qb.size() + qaa.size() + qba.size(), 32'd0);

    // Re-reset so the round-robin pointer prefers ch0, then contend.
    reset = 1'b1; cyc(); cyc(); reset = 1'b0; cyc();
    ch0_address = 22'h000800; ch1_address = 22'h000C00;
    ch0_as = 1'b1; ch1_as = 1'b1;
    qaa.push_back(21'h000400); qaa.push_back(21'h000600);
    qaa.push_back(21'h000400); qaa.push_back(21'h000600);
    qba.push_back(21'h000400); qba.push_back(21'h000400);
    qba.push_back(21'h000400); qba.push_back(21'h000600);
    serve(0, 16'h000F, 4, 16'h5000, 16'h5001, 16'h5002, 16'h5003, 1'b0, 1'b0);
    t_first = t_req;
    serve(0, 16'h000F, 4, 16'h5010, 16'h5011, 16'h5012, 16'h5013, 1'b1, 1'b0);
    chk("t2.burst_period", t_req - t_first, 32'd7);
    serve(0, 16'h000F, 4, 16'h5020, 16'h5021, 16'h5022, 16'h5023, 1'b0, 1'b0);
    ch0_as = 1'b0;
    serve(0, 16'h000F, 4, 16'h5030, 16'h5031, 16'h5032, 16'h5033, 1'b1, 1'b1);
    ch1_as = 1'b0;
    cyc(); cyc();
    chk("t2.drain", qa.size() + qb.size() + qaa.size() + qba.size(), 32'd0);

    // ch1 at a 4-byte aligned address, gappy rvalid, as dropped mid-burst.
    ch1_address = 22'h000404; ch1_as = 1'b1;
    qaa.push_back(21'h000202); qba.push_back(21'h000202);
    cyc();
    ch1_as = 1'b0;
    serve(1, 16'h0059, 7, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 1'b1, 1'b1);
    cyc(); cyc();
    chk("t3.A.ch0_din_hold", a_d0, 32'h5023);
    chk("t3.B.ch0_din_hold", b_d0, 32'h5023);
    chk("t3.drain", qa.size() + qb.size() + qaa.size() + qba.size(), 32'd0);

    // ch0 holds as across the ack and moves its address during TURN.
    ch0_address = 22'h000500; ch0_as = 1'b1;
    qaa.push_back(21'h000280); qba.push_back(21'h000280);
    serve(1, 16'h000F, 4, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 1'b0, 1'b0);
    ch0_address = 22'h000508;
    qaa.push_back(21'h000284); qba.push_back(21'h000284);
    serve(0, 16'h000F, 4, 16'hC010, 16'hC011, 16'hC012, 16'hC013, 1'b0, 1'b0);
    ch0_as = 1'b0;
    cyc(); cyc();
    chk("t4.drain", qa.size() + qb.size() + qaa.size() + qba.size(), 32'd0);

    // Reset after the second word; trailing rvalids must be ignored.
    ch0_address = 22'h000600; ch0_as = 1'b1;
    qaa.push_back(21'h000300); qba.push_back(21'h000300);
    wait_req();
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0; ch0_as = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'h7001 + 16'(i);
      e.ch = 1'b0; e.data = mem_rdata; e.last = 1'b0; e.cyc = cyc_cnt + 1;
      qa.push_back(e); qb.push_back(e);
      cyc();
    end
    mem_rvalid = 1'b0;
    cyc();
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h7003;
    cyc();
    chk_zero("t5.reset");
    reset = 1'b0; mem_rdata = 16'h7004;
    cyc();
    mem_rvalid = 1'b0;
    cyc(); cyc();
    chk("t5.drain", qa.size() + qb.size() + qaa.size() + qba.size(), 32'd0);
    ch1_address = 22'h0000A0; ch1_as = 1'b1;
    qaa.push_back(21'h000050); qba.push_back(21'h000050);
    serve(0, 16'h000F, 4, 16'hE000, 16'hE001, 16'hE002, 16'hE003, 1'b1, 1'b1);
    ch1_as = 1'b0;
    cyc(); cyc();
    chk("final.drain", qa.size() + qb.size() + qaa.size() + qba.size(), 32'd0);
    chk("final.A.idle", {a_req, a_v0, a_v1, a_k0, a_k1}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
